mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 188 ++++++++++++++++++
 tb/tb_mem_access.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: EX->MEM handshake, single outstanding data-bus access, WB result.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_write_data,
  input  logic        reg_write_en,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] current_pc_addr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        wb_reg_write_en,
  output logic [4:0]  wb_reg_write_addr,
  output logic [31:0] wb_pc,
  output logic        stall_req,
  output logic        bus_err,
  output logic        misalign_exc
);

  typedef enum logic {IDLE, BUS} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  logic [31:0] wait_cnt;

  size_t       op_size;
  logic [1:0]  op_off;
  logic        op_sign;
  logic        op_we;
  logic        op_rwe;
  logic [4:0]  op_rwa;
  logic [31:0] op_pc;
  logic [31:0] op_alu;

  size_t       in_size;
  logic [1:0]  in_off;
  logic        in_mem;
  logic        in_mis;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  logic [31:0] lane;
  logic [31:0] load_data;

  assign in_ready  = (state == IDLE);
  assign stall_req = (state == BUS);
  assign in_mem    = mem_read_flag | mem_write_flag;

  // Undefined mem_sel codes fall through to word; the byte offset is
  // reduced to what the access width can actually use.
  always_comb begin
    in_size  = SZ_W;
    in_off   = 2'b00;
    in_be    = 4'b1111;
    in_wdata = mem_write_data;
    case (mem_sel)
      4'b0001: begin
        in_size  = SZ_B;
        in_off   = alu_result[1:0];
        in_be    = 4'b0001 << alu_result[1:0];
        in_wdata = {4{mem_write_data[7:0]}};
      end
      4'b0011: begin
        in_size  = SZ_H;
        in_off   = {alu_result[1], 1'b0};
        in_be    = 4'b0011 << {alu_result[1], 1'b0};
        in_wdata = {2{mem_write_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign in_mis = in_mem & (((in_size == SZ_H) & alu_result[0]) |
                            ((in_size == SZ_W) & (|alu_result[1:0])));
`else
  assign in_mis = 1'b0;
`endif

  always_comb begin
    lane = dbus_rdata >> {op_off, 3'b000};
    case (op_size)
      SZ_B:    load_data = {{24{op_sign & lane[7]}}, lane[7:0]};
      SZ_H:    load_data = {{16{op_sign & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      op_size           <= SZ_W;
      op_off            <= '0;
      op_sign           <= 1'b0;
      op_we             <= 1'b0;
      op_rwe            <= 1'b0;
      op_rwa            <= '0;
      op_pc             <= '0;
      op_alu            <= '0;
      dbus_req          <= 1'b0;
      dbus_we           <= 1'b0;
      dbus_addr         <= '0;
      dbus_be           <= '0;
      dbus_wdata        <= '0;
      wb_valid          <= 1'b0;
      wb_data           <= '0;
      wb_reg_write_en   <= 1'b0;
      wb_reg_write_addr <= '0;
      wb_pc             <= '0;
      bus_err           <= 1'b0;
      misalign_exc      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_size <= in_size;
            op_off  <= in_off;
            op_sign <= mem_sign_flag;
            op_we   <= mem_write_flag;
            op_rwe  <= reg_write_en;
            op_rwa  <= reg_write_addr;
            op_pc   <= current_pc_addr;
            op_alu  <= alu_result;
            if (in_mem && !in_mis) begin
              state      <= BUS;
              wait_cnt   <= '0;
              dbus_req   <= 1'b1;
              dbus_we    <= mem_write_flag;
              dbus_addr  <= {alu_result[31:2], 2'b00};
              dbus_be    <= in_be;
              dbus_wdata <= in_wdata;
            end else begin
              wb_valid          <= 1'b1;
              wb_data           <= alu_result;
              wb_reg_write_en   <= reg_write_en & ~in_mis;
              wb_reg_write_addr <= reg_write_addr;
              wb_pc             <= current_pc_addr;
              misalign_exc      <= in_mis;
            end
          end
        end
        BUS: begin
          if (dbus_ack) begin
            state             <= IDLE;
            dbus_req          <= 1'b0;
            wb_valid          <= 1'b1;
            wb_data           <= op_we ? op_alu : load_data;
            wb_reg_write_en   <= op_rwe & ~op_we;
            wb_reg_write_addr <= op_rwa;
            wb_pc             <= op_pc;
          end else if (BUS_TIMEOUT != 0 && wait_cnt == BUS_TIMEOUT - 1) begin
            state             <= IDLE;
            dbus_req          <= 1'b0;
            wb_valid          <= 1'b1;
            bus_err           <= 1'b1;
            wb_reg_write_en   <= 1'b0;
            wb_reg_write_addr <= op_rwa;
            wb_pc             <= op_pc;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against an arithmetic reference model.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        mem_read_flag, mem_write_flag, mem_sign_flag;
  logic [3:0]  mem_sel;
  logic [31:0] alu_result, mem_write_data, current_pc_addr;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        wb_valid, wb_reg_write_en;
  logic [31:0] wb_data, wb_pc;
  logic [4:0]  wb_reg_write_addr;
  logic        stall_req, bus_err, misalign_exc;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access #(.BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_flag(mem_sign_flag), .mem_sel(mem_sel), .alu_result(alu_result),
    .mem_write_data(mem_write_data), .reg_write_en(reg_write_en),
    .reg_write_addr(reg_write_addr), .current_pc_addr(current_pc_addr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg_write_en(wb_reg_write_en), .wb_reg_write_addr(wb_reg_write_addr),
    .wb_pc(wb_pc), .stall_req(stall_req), .bus_err(bus_err),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // One complete transaction. waits < 0 means the bus never acknowledges.
  task automatic run_op(input logic rd, input logic wr, input logic sgn,
                        input logic [3:0] sel, input logic [31:0] alu,
                        input logic [31:0] wd, input logic rwe, input logic [4:0] rwa,
                        input logic [31:0] pc, input int waits, input logic [31:0] rdata,
                        input logic chk_stall);
    longint nb, off, be, wexp, v, lowmask;
    bit     mem, mis, tmo;
    int     cyc, stalls;
    nb      = (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
    off     = longint'(alu % 4) - longint'(alu % 32'(nb));
    be      = ((64'd1 << nb) - 1) << off;
    lowmask = (64'd1 << (8 * nb)) - 1;
    wexp    = 0;
    for (int k = 0; k < 4 / nb; k++) wexp = wexp | ((longint'(wd) & lowmask) << (8 * nb * k));
    v = (longint'(rdata) >> (8 * off)) & lowmask;
    if (sgn && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    mem = rd || wr;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem && (alu % 32'(nb) != 0);
`else
    mis = 1'b0;
`endif
    tmo = (waits < 0);

    @(negedge clk);
    in_valid = 1'b1; mem_read_flag = rd; mem_write_flag = wr; mem_sign_flag = sgn;
    mem_sel = sel; alu_result = alu; mem_write_data = wd; reg_write_en = rwe;
    reg_write_addr = rwa; current_pc_addr = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;

    if (!mem || mis) begin
      check("imm_wb_valid", 32'(wb_valid), 32'd1);
      check("imm_wb_data", wb_data, alu);
      check("imm_wb_rwe", 32'(wb_reg_write_en), 32'(rwe && !mis));
      check("imm_wb_rwa", 32'(wb_reg_write_addr), 32'(rwa));
      check("imm_wb_pc", wb_pc, pc);
      check("imm_misalign", 32'(misalign_exc), 32'(mis));
      check("imm_no_req", 32'(dbus_req), 32'd0);
      @(posedge clk); #1;
      check("imm_pulse_valid", 32'(wb_valid), 32'd0);
      check("imm_pulse_mis", 32'(misalign_exc), 32'd0);
      check("imm_no_req2", 32'(dbus_req), 32'd0);
      return;
    end

    cyc = 0; stalls = 0;
    while (cyc < 64) begin
      check("bus_req", 32'(dbus_req), 32'd1);
      check("bus_addr", dbus_addr, {alu[31:2], 2'b00});
      check("bus_be", 32'(dbus_be), 32'(be));
      check("bus_we", 32'(dbus_we), 32'(wr));
      if (wr) check("bus_wdata", dbus_wdata, 32'(wexp));
      check("bus_in_ready", 32'(in_ready), 32'd0);
      check("bus_no_wb", 32'(wb_valid), 32'd0);
      if (stall_req) stalls++;
      if (!tmo && cyc == waits) begin dbus_ack = 1'b1; dbus_rdata = rdata; end
      else dbus_rdata = $urandom;
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      cyc++;
      if ((!tmo && cyc > waits) || (tmo && cyc == TMO)) break;
    end
    if (chk_stall) check("stall_cycles", 32'(stalls), tmo ? 32'(TMO) : 32'(waits + 1));
    check("done_req", 32'(dbus_req), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
    check("done_stall", 32'(stall_req), 32'd0);
    check("done_wb_valid", 32'(wb_valid), 32'd1);
    check("done_bus_err", 32'(bus_err), 32'(tmo));
    check("done_rwe", 32'(wb_reg_write_en), 32'(rwe && !wr && !tmo));
    check("done_rwa", 32'(wb_reg_write_addr), 32'(rwa));
    check("done_pc", wb_pc, pc);
    check("done_misalign", 32'(misalign_exc), 32'd0);
    if (!wr && !tmo) check("load_data", wb_data, 32'(v));
    @(posedge clk); #1;
    check("pulse_valid", 32'(wb_valid), 32'd0);
    check("pulse_bus_err", 32'(bus_err), 32'd0);
  endtask

  initial begin
    logic [3:0]  sel_tab [4];
    logic [31:0] saved_data;
    bit          r, w;
    int          waits;
    sel_tab[0] = 4'b0001; sel_tab[1] = 4'b0011; sel_tab[2] = 4'b1111; sel_tab[3] = 4'b0000;

    rst_n = 1'b0; in_valid = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    mem_read_flag = 1'b0; mem_write_flag = 1'b0; mem_sign_flag = 1'b0; mem_sel = 4'b0000;
    alu_result = '0; mem_write_data = '0; reg_write_en = 1'b0; reg_write_addr = '0;
    current_pc_addr = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    run_op(0, 0, 0, 4'b1111, 32'h1234, 32'h0, 1, 5'd5, 32'h400, 0, 32'h0, 1);
    run_op(1, 0, 1, 4'b0001, 32'h103, 32'h0, 1, 5'd7, 32'h404, 3, 32'h80FF0000, 1);
    run_op(0, 1, 0, 4'b0011, 32'h202, 32'hABCD1234, 1, 5'd9, 32'h408, 0, 32'h0, 1);
    run_op(1, 0, 0, 4'b1111, 32'h300, 32'h0, 1, 5'd3, 32'h40C, -1, 32'h0, 1);
    run_op(1, 0, 0, 4'b1111, 32'h102, 32'h0, 1, 5'd4, 32'h410, 0, 32'hCAFEF00D, 1);
    run_op(1, 1, 0, 4'b0001, 32'h501, 32'h5A, 1, 5'd6, 32'h414, 1, 32'h0, 1);

    // Ack while idle must have no effect
    @(negedge clk); dbus_ack = 1'b1;
    @(posedge clk); #1; dbus_ack = 1'b0;
    check("idle_ack_wb", 32'(wb_valid), 32'd0);
    check("idle_ack_ready", 32'(in_ready), 32'd1);

    // Reset during an in-flight access
    saved_data = wb_data;
    @(negedge clk);
    in_valid = 1'b1; mem_read_flag = 1'b1; mem_write_flag = 1'b0; mem_sel = 4'b1111;
    alu_result = 32'h600; reg_write_en = 1'b1; reg_write_addr = 5'd2;
    @(posedge clk); #1; in_valid = 1'b0;
    check("rstmid_req_before", 32'(dbus_req), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("rstmid_req_async", 32'(dbus_req), 32'd0);
    check("rstmid_ready", 32'(in_ready), 32'd1);
    check("rstmid_wb", 32'(wb_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; dbus_ack = 1'b0;
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    check("late_ack_req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;
    check("late_ack_wb2", 32'(wb_valid), 32'd0);
    check("late_ack_data", wb_data, 32'd0);
    if (saved_data == 32'hFFFF_FFFF) check("unused_saved", wb_data, 32'd0);
    run_op(0, 0, 0, 4'b0001, 32'h777, 32'h0, 1, 5'd11, 32'h500, 0, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = ($urandom_range(0, 2) != 0);
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin r = 1'b0; w = 1'b0; end
      waits = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      run_op(r, w, 1'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : sel_tab[$urandom_range(0, 2)],
             $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, waits, $urandom, 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
